ps2_host_tx: RTL

- PS/2 host-to-device transmitter. It is the send side of the same link the keyboard receiver listens on.
- Sends command bytes to the keyboard, e.g. 0xFF reset, 0xED set LEDs, 0xF4 enable.
- Drives the open-collector PS/2 clock and data lines through output-enable pins only.
- Sits beside the keyboard receiver in the top level; the pad tristates are built there from the oe outputs.

---
 rtl/ps2_host_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked by the device, ACK check.
// Define PS2_TX_RETRY_EN to resend automatically (up to RETRY_MAX times) after a NACK or timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned RETRY_MAX      = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

`ifdef PS2_TX_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nx;
  logic        clk_s1, clk_s2, clk_prev;
  logic        dat_s1, dat_s2;
  logic        clk_fall;
  logic [19:0] inh_cnt;
  logic [19:0] to_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  tx_byte;
  logic        tx_par;
  logic [9:0]  frame;
  logic        dat_drv;
  logic [7:0]  retry_cnt;
  logic        accept, inh_last, active, timeout, retry_ok, failed;

  assign clk_fall = clk_prev & ~clk_s2;
  assign tx_ready = (state == S_IDLE);
  assign accept   = tx_valid && (state == S_IDLE);
  assign inh_last = (inh_cnt == 20'(INHIBIT_CYCLES - 1));
  assign active   = (state == S_RTS) || (state == S_SEND) ||
                    (state == S_ACK) || (state == S_WAIT_IDLE);
  assign timeout  = active && (to_cnt == 20'(TIMEOUT_CYCLES - 1));
  assign retry_ok = RETRY_EN && (retry_cnt < 8'(RETRY_MAX));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    failed     = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nx = S_INHIBIT;
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = inh_last;
        if (inh_last) state_nx = S_RTS;
      end
      S_RTS: begin
        ps2_dat_oe = 1'b1;
        if (timeout) failed = 1'b1;
        else         state_nx = S_SEND;
      end
      S_SEND: begin
        ps2_dat_oe = dat_drv;
        if (timeout)                          failed   = 1'b1;
        else if (clk_fall && bit_cnt == 4'd9) state_nx = S_ACK;
      end
      S_ACK: begin
        if (timeout)       failed = 1'b1;
        else if (clk_fall) begin
          if (dat_s2) failed   = 1'b1;
          else        state_nx = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (timeout)              failed   = 1'b1;
        else if (clk_s2 && dat_s2) state_nx = S_DONE;
      end
      S_DONE: begin
        tx_done  = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        tx_error = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (failed) state_nx = retry_ok ? S_INHIBIT : S_ERR;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_prev  <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      tx_byte   <= '0;
      tx_par    <= 1'b0;
      frame     <= '0;
      dat_drv   <= 1'b0;
      retry_cnt <= '0;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat_in;
      dat_s2   <= dat_s1;

      if (accept) begin
        tx_byte   <= tx_data;
        tx_par    <= ~^tx_data;
        frame     <= {1'b1, ~^tx_data, tx_data};
        retry_cnt <= '0;
      end else if (state != S_IDLE && state != S_INHIBIT && state_nx == S_INHIBIT) begin
        // retry: rebuild the frame from the latched byte, the shifted copy is spent
        frame     <= {1'b1, tx_par, tx_byte};
        retry_cnt <= retry_cnt + 8'd1;
      end else if (state == S_SEND && clk_fall && !timeout) begin
        frame <= {1'b0, frame[9:1]};
      end

      if (state_nx == S_INHIBIT && state != S_INHIBIT) inh_cnt <= '0;
      else if (state == S_INHIBIT && !inh_last)        inh_cnt <= inh_cnt + 20'd1;

      if (state_nx == S_RTS && state != S_RTS) begin
        to_cnt  <= '0;
        bit_cnt <= '0;
        dat_drv <= 1'b1;
      end else begin
        if (active && !timeout) to_cnt <= to_cnt + 20'd1;
        if (state == S_SEND && clk_fall && !timeout) begin
          dat_drv <= ~frame[0];
          if (bit_cnt != 4'd10) bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule
